// File: rtl/riscv_core.sv
// riscv_core: multi-cycle RV32I integer core (FETCH -> EXEC [-> MEM]) with a single memory port.
// Define RISCV_CORE_CYCLE_CSR_EN to add the 64-bit cycle counter read by rdcycle/rdcycleh.
module riscv_core (
  input  logic        clock,
  input  logic        rst,
  input  logic        ce,
  output logic [31:0] a,
  input  logic [31:0] i,
  output logic [31:0] o,
  output logic        w,
  output logic [1:0]  ws,
  output logic [1:0]  dbg_state
);
  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, MEM = 2'd2} state_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] rf [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1v, rs2v, pc4;
  logic [31:0] alu_b, alu_y, load_y;
  logic [4:0]  shamt;
  logic        alu_alt, taken;
  logic        exec_we, mem_go, store_go;
  logic [31:0] exec_wd, exec_pc, mem_addr;
  logic        rf_we;
  logic [31:0] rf_wd;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u  = {ir[31:12], 12'h000};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign rs1v = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2v = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign pc4  = pc + 32'd4;
  assign dbg_state = state;

`ifdef RISCV_CORE_CYCLE_CSR_EN
  logic [63:0] cycle;
  always_ff @(posedge clock) begin
    if (rst) cycle <= 64'd0;
    else if (ce) cycle <= cycle + 64'd1;
  end
`endif

  // Shared ALU for OP and OP-IMM; bit 30 selects SUB/SRA(I) only where it is meaningful.
  always_comb begin
    alu_b   = (opcode == OP_REG) ? rs2v : imm_i;
    shamt   = alu_b[4:0];
    alu_alt = ir[30] && ((opcode == OP_REG) || (f3 == 3'b101));
    alu_y   = 32'd0;
    case (f3)
      3'b000:  alu_y = alu_alt ? (rs1v - alu_b) : (rs1v + alu_b);
      3'b001:  alu_y = rs1v << shamt;
      3'b010:  alu_y = {31'd0, ($signed(rs1v) < $signed(alu_b))};
      3'b011:  alu_y = {31'd0, (rs1v < alu_b)};
      3'b100:  alu_y = rs1v ^ alu_b;
      3'b101:  alu_y = alu_alt ? 32'($signed(rs1v) >>> shamt) : (rs1v >> shamt);
      3'b110:  alu_y = rs1v | alu_b;
      default: alu_y = rs1v & alu_b;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000:  taken = (rs1v == rs2v);
      3'b001:  taken = (rs1v != rs2v);
      3'b100:  taken = ($signed(rs1v) < $signed(rs2v));
      3'b101:  taken = !($signed(rs1v) < $signed(rs2v));
      3'b110:  taken = (rs1v < rs2v);
      3'b111:  taken = !(rs1v < rs2v);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    load_y = i;
    case (f3)
      3'b000:  load_y = {{24{i[7]}}, i[7:0]};
      3'b001:  load_y = {{16{i[15]}}, i[15:0]};
      3'b100:  load_y = {24'd0, i[7:0]};
      3'b101:  load_y = {16'd0, i[15:0]};
      default: load_y = i;
    endcase
  end

  // Anything not decoded here (FENCE, ECALL/EBREAK, CSRs, bad funct3) falls through as pc += 4.
  always_comb begin
    exec_we  = 1'b0;
    exec_wd  = alu_y;
    exec_pc  = pc4;
    mem_go   = 1'b0;
    store_go = 1'b0;
    mem_addr = rs1v + imm_i;
    case (opcode)
      OP_LUI:   begin exec_we = 1'b1; exec_wd = imm_u; end
      OP_AUIPC: begin exec_we = 1'b1; exec_wd = pc + imm_u; end
      OP_JAL:   begin exec_we = 1'b1; exec_wd = pc4; exec_pc = pc + imm_j; end
      OP_JALR: begin
        if (f3 == 3'b000) begin
          exec_we = 1'b1;
          exec_wd = pc4;
          exec_pc = (rs1v + imm_i) & ~32'd1;
        end
      end
      OP_BR:    if (taken) exec_pc = pc + imm_b;
      OP_IMM:   exec_we = 1'b1;
      OP_REG:   exec_we = 1'b1;
      OP_LOAD:  mem_go = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      OP_STORE: begin
        mem_addr = rs1v + imm_s;
        store_go = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        mem_go   = store_go;
      end
`ifdef RISCV_CORE_CYCLE_CSR_EN
      OP_SYS: begin
        if (f3 == 3'b010 && rs1 == 5'd0) begin
          if (ir[31:20] == 12'hC00) begin exec_we = 1'b1; exec_wd = cycle[31:0]; end
          if (ir[31:20] == 12'hC80) begin exec_we = 1'b1; exec_wd = cycle[63:32]; end
        end
      end
`endif
      default: exec_we = 1'b0;
    endcase
  end

  always_comb begin
    rf_we = 1'b0;
    rf_wd = exec_wd;
    if (state == EXEC) begin
      rf_we = exec_we;
    end else if (state == MEM && opcode == OP_LOAD) begin
      rf_we = 1'b1;
      rf_wd = load_y;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst && ce && rf_we && rd != 5'd0) rf[rd] <= rf_wd;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= FETCH;
      pc    <= 32'd0;
      ir    <= 32'd0;
      a     <= 32'd0;
      o     <= 32'd0;
      w     <= 1'b0;
      ws    <= 2'b10;
    end else if (ce) begin
      case (state)
        FETCH: begin
          ir    <= i;
          state <= EXEC;
        end
        EXEC: begin
          if (mem_go) begin
            a <= mem_addr;
            if (store_go) begin
              o  <= rs2v;
              ws <= f3[1:0];
              w  <= 1'b1;
            end
            state <= MEM;
          end else begin
            pc    <= exec_pc;
            a     <= exec_pc;
            state <= FETCH;
          end
        end
        MEM: begin
          w     <= 1'b0;
          a     <= pc4;
          pc    <= pc4;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_core.sv
// tb_riscv_core: byte-addressed memory model, store scoreboard and directed/random program tests.
module tb_riscv_core;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic [31:0] a, i, o;
  logic        w;
  logic [1:0]  ws, dbg_state;

  logic [7:0]  mem [4096];
  logic [65:0] exp_q [$];
  logic [65:0] got_s, exp_s;
  logic [31:0] pa;
  int          checks = 0;
  int          errors = 0;

  riscv_core dut (
    .clock(clock), .rst(rst), .ce(ce), .a(a), .i(i),
    .o(o), .w(w), .ws(ws), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clock = ~clock;

  assign i = {mem[a[11:0] + 12'd3], mem[a[11:0] + 12'd2], mem[a[11:0] + 12'd1], mem[a[11:0]]};

  // A store is presented while w is high on an enabled, non-reset cycle; it commits at the next edge.
  always @(negedge clock) begin
    if (rst === 1'b0 && ce === 1'b1 && w === 1'b1) begin
      mem[a[11:0]] = o[7:0];
      if (ws != 2'b00) mem[a[11:0] + 12'd1] = o[15:8];
      if (ws == 2'b10) begin
        mem[a[11:0] + 12'd2] = o[23:16];
        mem[a[11:0] + 12'd3] = o[31:24];
      end
      got_s = {a, ws, o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL store_unexpected got a=%h ws=%b o=%h required no store", a, ws, o);
      end else begin
        exp_s = exp_q.pop_front();
        if (got_s !== exp_s) begin
          errors++;
          $display("FAIL store got a=%h ws=%b o=%h required a=%h ws=%b o=%h",
                   a, ws, o, exp_s[65:34], exp_s[33:32], exp_s[31:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // instruction encoders
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], OP_STORE};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], OP_BR};
  endfunction
  function automatic logic [31:0] enc_u(int imm, int rd, logic [6:0] op);
    return {imm[19:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], OP_JAL};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OP_REG};
  endfunction

  function automatic logic [31:0] ref_alu(int op, logic [31:0] x, logic [31:0] y);
    case (op)
      0: return x + y;
      1: return x - y;
      2: return x << y[4:0];
      3: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4: return (x < y) ? 32'd1 : 32'd0;
      5: return x ^ y;
      6: return x >> y[4:0];
      7: return 32'($signed(x) >>> y[4:0]);
      8: return x | y;
      default: return x & y;
    endcase
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic begin_prog();
    rst = 1'b1;
    ce  = 1'b1;
    tick();
    for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
    exp_q.delete();
    pa = 32'd0;
  endtask

  task automatic org(input logic [31:0] addr);
    pa = addr;
  endtask

  task automatic emit(input logic [31:0] word);
    mem[pa[11:0]]          = word[7:0];
    mem[pa[11:0] + 12'd1]  = word[15:8];
    mem[pa[11:0] + 12'd2]  = word[23:16];
    mem[pa[11:0] + 12'd3]  = word[31:24];
    pa = pa + 32'd4;
  endtask

  task automatic expect_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data);
    exp_q.push_back({addr, sz, data});
  endtask

  task automatic run_prog(input string name, input int budget);
    int n;
    rst = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    repeat (12) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending stores required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    begin_prog();
    emit(enc_i(1, 0, 0, 1, OP_IMM));
    emit(enc_j(0, 0));
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    ce  = 1'b0;
    tick();
    checks++;
    if ({a, o, w, ws, dbg_state} !== {32'h0, 32'h0, 1'b0, 2'b10, 2'd0}) begin
      errors++;
      $display("FAIL reset_state got a=%h o=%h w=%b ws=%b st=%0d required a=0 o=0 w=0 ws=10 st=0",
               a, o, w, ws, dbg_state);
    end
    rst = 1'b0;
    ce  = 1'b1;
    checks++;
    if ({a, w} !== {32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_first_fetch got a=%h w=%b required a=00000000 w=0", a, w);
    end
    repeat (2) tick();
    checks++;
    if (a !== 32'h4) begin
      errors++;
      $display("FAIL reset_second_fetch got a=%h required 00000004", a);
    end
  endtask

  task automatic test_fetch_timing();
    logic [31:0] want [3];
    want[0] = 32'h10;
    want[1] = 32'h18;
    want[2] = 32'h10;
    begin_prog();
    emit(enc_j(16, 0));
    org(32'h10); emit(enc_j(8, 1));
    org(32'h18); emit(enc_b(-8, 0, 0, 0));
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (2) tick();
      checks++;
      if (a !== want[k]) begin
        errors++;
        $display("FAIL fetch_timing_%0d got a=%h required %h", k, a, want[k]);
      end
    end
  endtask

  task automatic test_store_word();
    begin_prog();
    emit(enc_i(5, 0, 0, 1, OP_IMM));
    emit(enc_i(-3, 1, 0, 2, OP_IMM));
    emit(enc_s(32'h100, 2, 0, 2));
    emit(enc_j(0, 0));
    expect_store(32'h100, 2'b10, 32'h2);
    run_prog("store_word", 200);
  endtask

  task automatic test_byte_load();
    begin_prog();
    emit(enc_u(32'h12345, 3, OP_LUI));
    emit(enc_i(32'h80, 3, 0, 3, OP_IMM));
    emit(enc_s(32'h104, 3, 0, 0));
    emit(enc_i(32'h104, 0, 0, 4, OP_LOAD));
    emit(enc_i(32'h104, 0, 4, 5, OP_LOAD));
    emit(enc_s(32'h108, 4, 0, 2));
    emit(enc_s(32'h10C, 5, 0, 2));
    emit(enc_u(32'hABCD8, 7, OP_LUI));
    emit(enc_s(32'h112, 7, 0, 1));
    emit(enc_i(32'h112, 0, 1, 8, OP_LOAD));
    emit(enc_i(32'h112, 0, 5, 9, OP_LOAD));
    emit(enc_s(32'h118, 8, 0, 2));
    emit(enc_s(32'h11C, 9, 0, 2));
    emit(enc_i(32'h111, 0, 2, 10, OP_LOAD));
    emit(enc_s(32'h120, 10, 0, 2));
    emit(enc_j(0, 0));
    expect_store(32'h104, 2'b00, 32'h12345080);
    expect_store(32'h108, 2'b10, 32'hFFFFFF80);
    expect_store(32'h10C, 2'b10, 32'h00000080);
    expect_store(32'h112, 2'b01, 32'hABCD8000);
    expect_store(32'h118, 2'b10, 32'hFFFF8000);
    expect_store(32'h11C, 2'b10, 32'h00008000);
    expect_store(32'h120, 2'b10, 32'h00800000);
    run_prog("byte_load", 400);
  endtask

  task automatic test_control_flow();
    logic [31:0] marker;
    marker = enc_s(32'h1F0, 0, 0, 2);
    begin_prog();
    emit(enc_j(8, 1));
    emit(marker);
    emit(enc_b(8, 0, 0, 1));
    emit(enc_s(32'h120, 1, 0, 2));
    emit(enc_b(8, 0, 0, 0));
    emit(marker);
    emit(enc_i(32'h1D, 1, 0, 2, OP_JALR));
    emit(marker);
    emit(enc_s(32'h124, 2, 0, 2));
    emit(enc_i(32'h30, 0, 0, 3, OP_IMM));
    emit(enc_i(0, 3, 0, 3, OP_JALR));
    emit(marker);
    emit(enc_s(32'h128, 3, 0, 2));
    emit(enc_i(-1, 0, 0, 4, OP_IMM));
    emit(enc_b(8, 0, 4, 4));
    emit(marker);
    emit(enc_b(8, 0, 4, 6));
    emit(enc_s(32'h12C, 4, 0, 2));
    emit(enc_b(8, 0, 4, 7));
    emit(marker);
    emit(enc_b(8, 4, 0, 5));
    emit(marker);
    emit(enc_j(0, 0));
    expect_store(32'h120, 2'b10, 32'h00000004);
    expect_store(32'h124, 2'b10, 32'h0000001C);
    expect_store(32'h128, 2'b10, 32'h0000002C);
    expect_store(32'h12C, 2'b10, 32'hFFFFFFFF);
    run_prog("control_flow", 400);
  endtask

  task automatic test_alu();
    logic [31:0] want [9];
    int regs [9];
    want[0] = 32'h0000000F; want[1] = 32'hFFFFFFFF; want[2] = 32'h1;
    want[3] = 32'h0;        want[4] = 32'h0;        want[5] = 32'h00001018;
    want[6] = 32'h1;        want[7] = 32'h0;        want[8] = 32'hFFFFFF0F;
    regs[0] = 7;  regs[1] = 8;  regs[2] = 9;  regs[3] = 10; regs[4] = 0;
    regs[5] = 14; regs[6] = 15; regs[7] = 16; regs[8] = 17;
    begin_prog();
    emit(enc_i(-1, 0, 0, 6, OP_IMM));
    emit(enc_i(28, 6, 5, 7, OP_IMM));
    emit(enc_i(32'h41C, 6, 5, 8, OP_IMM));
    emit(enc_r(0, 6, 0, 3, 9));
    emit(enc_r(0, 6, 0, 2, 10));
    emit(enc_i(7, 0, 0, 0, OP_IMM));
    emit(enc_u(1, 14, OP_AUIPC));
    emit(enc_i(0, 6, 2, 15, OP_IMM));
    emit(enc_i(1, 6, 3, 16, OP_IMM));
    emit(enc_i(32'hF0, 6, 4, 17, OP_IMM));
    for (int k = 0; k < 9; k++) begin
      emit(enc_s(32'h130 + 4 * k, regs[k], 0, 2));
      expect_store(32'h130 + 4 * k, 2'b10, want[k]);
    end
    emit(enc_j(0, 0));
    run_prog("alu", 400);
  endtask

  task automatic test_alu_random();
    logic [31:0] u1, u2, l1, l2, v1, v2;
    int op;
    int f7_tab [10];
    int f3_tab [10];
    f7_tab = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
    f3_tab = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    begin_prog();
    for (int k = 0; k < 10; k++) begin
      u1 = $urandom;
      u2 = $urandom;
      l1 = $urandom_range(0, 4095);
      l2 = $urandom_range(0, 4095);
      op = (k < 10) ? ((k + $urandom_range(0, 9)) % 10) : 0;
      v1 = {u1[19:0], 12'h000} + {{20{l1[11]}}, l1[11:0]};
      v2 = {u2[19:0], 12'h000} + {{20{l2[11]}}, l2[11:0]};
      emit(enc_u(u1, 11, OP_LUI));
      emit(enc_i(l1, 11, 0, 11, OP_IMM));
      emit(enc_u(u2, 12, OP_LUI));
      emit(enc_i(l2, 12, 0, 12, OP_IMM));
      emit(enc_r(f7_tab[op], 12, 11, f3_tab[op], 13));
      emit(enc_s(32'h200 + 4 * k, 13, 0, 2));
      expect_store(32'h200 + 4 * k, 2'b10, ref_alu(op, v1, v2));
    end
    emit(enc_j(0, 0));
    run_prog("alu_random", 600);
  endtask

  task automatic test_system_nop();
    begin_prog();
    emit(enc_i(32'h55, 0, 0, 5, OP_IMM));
    emit(enc_i(32'h66, 0, 0, 6, OP_IMM));
    emit(enc_i(32'hC00, 0, 2, 5, OP_SYS));
    emit(enc_i(32'hC80, 0, 2, 6, OP_SYS));
    emit(32'h0000000F);
    emit(32'h00000073);
    emit(32'hFFFFFFFF);
    emit(enc_s(32'h160, 5, 0, 2));
    emit(enc_s(32'h164, 6, 0, 2));
    emit(enc_j(0, 0));
`ifdef RISCV_CORE_CYCLE_CSR_EN
    expect_store(32'h160, 2'b10, 32'h5);
    expect_store(32'h164, 2'b10, 32'h0);
`else
    expect_store(32'h160, 2'b10, 32'h55);
    expect_store(32'h164, 2'b10, 32'h66);
`endif
    run_prog("system_nop", 300);
  endtask

  task automatic store_prog_to_mem_stage(input string name);
    int n;
    begin_prog();
    emit(enc_i(5, 0, 0, 1, OP_IMM));
    emit(enc_i(-3, 1, 0, 2, OP_IMM));
    emit(enc_s(32'h100, 2, 0, 2));
    emit(enc_j(0, 0));
    expect_store(32'h100, 2'b10, 32'h2);
    rst = 1'b0;
    n = 0;
    while (w !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (w !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait got w=%b required 1 within 50 cycles", name, w);
    end
  endtask

  task automatic test_freeze();
    store_prog_to_mem_stage("freeze");
    ce = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({a, o, w, ws, dbg_state} !== {32'h100, 32'h2, 1'b1, 2'b10, 2'd2}) begin
        errors++;
        $display("FAIL freeze_hold_%0d got a=%h o=%h w=%b ws=%b st=%0d required a=100 o=2 w=1 ws=10 st=2",
                 k, a, o, w, ws, dbg_state);
      end
    end
    ce = 1'b1;
    tick();
    checks++;
    if ({a, w} !== {32'hC, 1'b0}) begin
      errors++;
      $display("FAIL freeze_resume got a=%h w=%b required a=0000000c w=0", a, w);
    end
    run_prog("freeze", 50);
  endtask

  task automatic test_reset_mem();
    store_prog_to_mem_stage("reset_mem");
    rst = 1'b1;
    tick();
    checks++;
    if ({a, w, dbg_state} !== {32'h0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_mem got a=%h w=%b st=%0d required a=0 w=0 st=0", a, w, dbg_state);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_fetch_timing();
    test_store_word();
    test_byte_load();
    test_control_flow();
    test_alu();
    test_alu_random();
    test_system_nop();
    test_freeze();
    test_reset_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_core.md
RISCV_CORE -- requirements
Module: riscv_core

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock in 1 (all state updates on rising edge); rst in 1 (active-high, sampled only on a rising clock edge).
REQ-002 The block SHALL expose: ce in 1 (clock enable); a out 32 (byte address); i in 32 (read data, little-endian, combinational from a); o out 32 (write data, LSB-aligned); w out 1 (write strobe); ws out 2 (write size).
REQ-003 ws SHALL be encoded 00 = byte o[7:0], 01 = halfword o[15:0], 10 = word o[31:0]; 11 SHALL never be driven.
REQ-004 a, o, w and ws SHALL be registered outputs.

Function
REQ-005 The block SHALL implement RV32I user integer instructions: LUI, AUIPC, JAL, JALR, branches, loads, stores, OP-IMM and OP.
REQ-006 The block SHALL keep 32 x 32-bit registers; x0 reads 0 and writes to x0 are discarded.
REQ-007 The block SHALL use FSM states FETCH, EXEC and MEM.
REQ-008 FETCH: a = pc; at the edge, ir <= i; next state EXEC.
REQ-009 EXEC, non-memory instruction: write rd, update pc and set a <= new pc at the edge; next state FETCH (2 cycles per instruction).
REQ-010 EXEC, load/store: a <= rs1 + sext(imm); next state MEM.
REQ-011 EXEC, store additionally: o <= rs2; ws <= funct3[1:0]; w <= 1.
REQ-012 MEM, load: rd <= i[7:0] / i[15:0] / i[31:0], sign-extended (LB/LH) or zero-extended (LBU/LHU).
REQ-013 MEM, either type: w <= 0; a <= pc+4; pc <= pc+4; next state FETCH (3 cycles per memory instruction).
REQ-014 w SHALL be high for exactly one enabled cycle per store.
REQ-015 Taken branch and JAL: pc += sext(imm).
REQ-016 JALR: pc = (rs1 + imm) & ~1.
REQ-017 JAL and JALR: rd = old pc + 4; rs1 is read before rd is written, so rd == rs1 is handled correctly.
REQ-018 All arithmetic SHALL be mod 2^32.
REQ-019 Shift amount SHALL be the low 5 bits; SRA and SRAI are arithmetic.
REQ-020 SLT, SLTI and branch comparisons SHALL be signed; SLTU, SLTIU, BLTU and BGEU SHALL be unsigned.
REQ-021 No alignment checks; misaligned addresses pass through unchanged.
REQ-022 FENCE, ECALL, EBREAK, CSR instructions (unless REQ-027 applies) and undefined opcodes SHALL execute as NOP (pc += 4).
REQ-023 ce = 0: state, registers and outputs SHALL freeze with no update; w holds its value.

Reset
REQ-024 rst = 1 at an edge: pc = 0, a = 0, o = 0, w = 0, ws = 10, state = FETCH; register file contents are don't-care except x0.
REQ-025 rst SHALL take precedence over ce.
REQ-026 Reset during MEM SHALL abort the access, w = 0 the next cycle.

Configuration
REQ-027 With macro RISCV_CORE_CYCLE_CSR_EN defined: a 64-bit cycle counter SHALL increment every enabled cycle, clear on reset, and be returned by CSRRS rd, x0 from CSR 0xC00 (low) / 0xC80 (high) (rdcycle/rdcycleh).
REQ-028 Without RISCV_CORE_CYCLE_CSR_EN: no counter; those instructions SHALL be NOPs and rd is unchanged.

Verification
REQ-029 Reset release: first cycle a = 0x00000000, w = 0; second instruction fetched at a = 0x4 two cycles later for an ALU instruction.
REQ-030 Store word: ADDI x1,x0,5; ADDI x2,x1,-3; SW x2,0x100(x0) -> one cycle with w = 1, ws = 10, a = 0x100, o = 0x00000002.
REQ-031 Byte store and load sign handling: LUI x3,0x12345; ADDI x3,x3,0x80; SB x3,0x104(x0) -> w = 1, ws = 00, o[7:0] = 0x80. Then LB x4,0x104(x0) -> x4 = 0xFFFFFF80; LBU x5,0x104(x0) -> x5 = 0x00000080.
REQ-032 Control flow: JAL x1,+8 at pc 0x10 -> x1 = 0x14, next fetch a = 0x18. BEQ x0,x0,-8 at 0x18 -> next fetch 0x10. BNE x0,x0 -> next fetch pc+4.
REQ-033 ALU edge cases: ADDI x6,x0,-1; SRLI x7,x6,28 -> 0x0000000F; SRAI x8,x6,28 -> 0xFFFFFFFF; SLTU x9,x0,x6 -> 1; SLT x10,x0,x6 -> 0; ADDI x0,x0,7 leaves x0 = 0.
REQ-034 Freeze: ce = 0 for 5 cycles mid-store -> a, o, w and ws held; no extra instruction retired; execution resumes identically when ce = 1.
